// File: rtl/ecap5_dproc_pkg.sv
// Shared constants and types for the writeback stage and its load alignment helper.
package ecap5_dproc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    // wen already folds in the rd != 0 check, so it doubles as the forward-valid flag
    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } slot_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word out of a raw memory word and extends it to XLEN.
module load_align
    import ecap5_dproc_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] value_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset_i)
            2'd0:    w_byte = data_i[7:0];
            2'd1:    w_byte = data_i[15:8];
            2'd2:    w_byte = data_i[23:16];
            default: w_byte = data_i[31:24];
        endcase
        // offset bit 0 is ignored for halves; misaligned halves never reach this stage
        w_half = offset_i[1] ? data_i[31:16] : data_i[15:0];

        case (size_i)
            LOAD_BYTE: value_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
            LOAD_HALF: value_o = {{16{~unsigned_i & w_half[15]}}, w_half};
            default:   value_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: one-entry retire slot driving the regm write port, operand
// forwarding, retired-instruction counter and debug write arbitration.
module writeback
    import ecap5_dproc_pkg::*;
#(
    parameter int RETIRE_CNT_W  = 64,
    parameter int DBG_ACK_DELAY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    input_valid_i,
    output logic                    input_ready_o,
    input  logic                    reg_write_i,
    input  logic [REG_ADDR_W-1:0]   reg_addr_i,
    input  logic [XLEN-1:0]         result_i,
    input  logic                    is_load_i,
    input  logic [1:0]              load_size_i,
    input  logic                    load_unsigned_i,
    input  logic [1:0]              load_offset_i,
    input  logic [XLEN-1:0]         load_data_i,
    input  logic                    dbg_req_i,
    input  logic [REG_ADDR_W-1:0]   dbg_waddr_i,
    input  logic [XLEN-1:0]         dbg_wdata_i,
    output logic                    dbg_ack_o,
    output logic                    reg_write_o,
    output logic [REG_ADDR_W-1:0]   reg_waddr_o,
    output logic [XLEN-1:0]         reg_wdata_o,
    output logic                    fwd_valid_o,
    output logic [REG_ADDR_W-1:0]   fwd_addr_o,
    output logic [XLEN-1:0]         fwd_data_o,
    output logic [RETIRE_CNT_W-1:0] instret_o
);

    if (DBG_ACK_DELAY != 1) begin : g_unsupported_ack_delay
        $error("writeback: only DBG_ACK_DELAY == 1 is implemented");
    end

    localparam logic [RETIRE_CNT_W-1:0] INSTRET_ONE = 1;

    logic                    w_accept;
    logic                    w_dbg_grant;
    logic [XLEN-1:0]         w_load_value;
    logic [XLEN-1:0]         w_slot_data;

    slot_t                   r_slot;
    logic                    r_dbg_ack;
    logic                    r_boot;
    logic [RETIRE_CNT_W-1:0] r_instret;

    load_align u_load_align (
        .size_i     (load_size_i),
        .unsigned_i (load_unsigned_i),
        .offset_i   (load_offset_i),
        .data_i     (load_data_i),
        .value_o    (w_load_value)
    );

    // A pending debug request stalls upstream so the slot drains and frees the write port.
    // The ack cycle and the first cycle out of reset are never grant cycles.
    always_comb begin
        input_ready_o = !dbg_req_i;
        w_accept      = input_valid_i && !dbg_req_i;
        w_slot_data   = is_load_i ? w_load_value : result_i;
        w_dbg_grant   = dbg_req_i && !r_slot.wen && !r_dbg_ack && !r_boot;

        reg_write_o = r_slot.wen;
        reg_waddr_o = r_slot.addr;
        reg_wdata_o = r_slot.data;
        if (w_dbg_grant) begin
            reg_write_o = (dbg_waddr_i != '0);
            reg_waddr_o = dbg_waddr_i;
            reg_wdata_o = dbg_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot    <= '0;
            r_dbg_ack <= 1'b0;
            r_boot    <= 1'b1;
            r_instret <= '0;
        end else begin
            r_boot     <= 1'b0;
            r_dbg_ack  <= w_dbg_grant;
            r_slot.wen <= w_accept && reg_write_i && (reg_addr_i != '0);
            if (w_accept) begin
                r_slot.addr <= reg_addr_i;
                r_slot.data <= w_slot_data;
                r_instret   <= r_instret + INSTRET_ONE;
            end
        end
    end

    assign dbg_ack_o   = r_dbg_ack;
    assign fwd_valid_o = r_slot.wen;
    assign fwd_addr_o  = r_slot.addr;
    assign fwd_data_o  = r_slot.data;
    assign instret_o   = r_instret;

endmodule
